switch_matrix_cfg: RTL

- Parametrised programmable switch box for the FPGA routing fabric: four sides (top/bottom with N_TB pins, left/right with N_LR pins); each pin output is driven from any pin of any side or left undriven.
- Replaces fixed in-module routing tables and bidirectional pins with split in/out/oe pins and a streaming configuration loader.
- The loader fills a shadow table and commits it atomically, so active routing never changes mid-load.

---
 rtl/switch_matrix_cfg.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/switch_matrix_cfg.sv
// ---------------------------------------------------------------------------
// switch_matrix_cfg
//   Programmable switch box for the routing fabric. Four sides of pins
//   (top/bottom: N_TB pins, left/right: N_LR pins). Each pin output is driven
//   from any pin input of any side, or left undriven (oe = 0, out = 0).
//
//   Routing comes from an "active" table. A streaming loader fills a separate
//   "shadow" table, one entry per slot, and copies it into the active table
//   in a single cycle. Routing therefore never changes part-way through a load.
//
//   Table slot numbering: top 0..N_TB-1, bottom N_TB..2*N_TB-1,
//   left 2*N_TB..2*N_TB+N_LR-1, right last N_LR slots.
//   Entry format: [2:0] source side (0 none, 1 top, 2 right, 3 bottom,
//   4 left), [IDX_W+2:3] source pin index on that side.
//
//   Optional build macro SWM_OUT_REG_EN: when defined, every *_out / *_oe is
//   registered (1-cycle latency from *_in, reset to 0). When undefined, the
//   outputs are combinational from the active table and the inputs.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   top_in/bottom_in         [N_TB] pin inputs
//   left_in/right_in         [N_LR] pin inputs
//   top_out/bottom_out       [N_TB] routed values
//   left_out/right_out       [N_LR] routed values
//   top_oe ... right_oe      per-pin drive enables
//   cfg_start                begin a full table load (honoured in IDLE only)
//   cfg_valid/cfg_ready      word handshake for cfg_data
//   cfg_data                 [IDX_W+3] table entry for the next slot
//   cfg_done                 one-cycle pulse in the commit cycle
//   cfg_err                  sticky: an entry of the current/last load was rejected
// ---------------------------------------------------------------------------
module switch_matrix_cfg #(
  parameter int N_TB  = 5,
  parameter int N_LR  = 4,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_TB-1:0]  top_in,
  input  logic [N_TB-1:0]  bottom_in,
  input  logic [N_LR-1:0]  left_in,
  input  logic [N_LR-1:0]  right_in,
  output logic [N_TB-1:0]  top_out,
  output logic [N_TB-1:0]  bottom_out,
  output logic [N_LR-1:0]  left_out,
  output logic [N_LR-1:0]  right_out,
  output logic [N_TB-1:0]  top_oe,
  output logic [N_TB-1:0]  bottom_oe,
  output logic [N_LR-1:0]  left_oe,
  output logic [N_LR-1:0]  right_oe,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W+2:0] cfg_data,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int SEL_W = IDX_W + 3;
  localparam int P     = 2*N_TB + 2*N_LR;
  localparam int CNT_W = $clog2(P);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(P-1);

  localparam logic [2:0] SIDE_NONE   = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic [SEL_W-1:0] shadow [P];
  logic [SEL_W-1:0] active [P];

  logic             wr_en;
  logic             wr_ok;
  logic [P-1:0]     pins_in;
  logic [P-1:0]     route_out;
  logic [P-1:0]     route_oe;
  logic [P-1:0]     pin_out;
  logic [P-1:0]     pin_oe;

  // First table slot belonging to a side.
  function automatic int side_base(input logic [2:0] side);
    case (side)
      SIDE_TOP:    return 0;
      SIDE_BOTTOM: return N_TB;
      SIDE_LEFT:   return 2*N_TB;
      SIDE_RIGHT:  return 2*N_TB + N_LR;
      default:     return 0;
    endcase
  endfunction

  function automatic int side_width(input logic [2:0] side);
    case (side)
      SIDE_TOP, SIDE_BOTTOM: return N_TB;
      SIDE_LEFT, SIDE_RIGHT: return N_LR;
      default:               return 0;
    endcase
  endfunction

  // An entry is legal when it is "undriven", or names an existing pin that
  // is not the slot being written (a pin may not loop back onto itself).
  function automatic logic entry_ok(input logic [SEL_W-1:0] entry,
                                    input logic [CNT_W-1:0] slot);
    logic [2:0] side;
    int         idx;
    side = entry[2:0];
    idx  = int'(entry[SEL_W-1:3]);
    if (side == SIDE_NONE) return 1'b1;
    if (side > SIDE_LEFT) return 1'b0;
    if (idx >= side_width(side)) return 1'b0;
    return (side_base(side) + idx) != int'(slot);
  endfunction

  function automatic logic entry_drives(input logic [SEL_W-1:0] entry);
    return (entry[2:0] != SIDE_NONE) && (entry[2:0] <= SIDE_LEFT);
  endfunction

  // Stored entries are always legal, so the shifted position is in range;
  // the shift keeps the select free of out-of-range indexing regardless.
  function automatic logic entry_bit(input logic [SEL_W-1:0] entry,
                                     input logic [P-1:0]     pins);
    logic [P-1:0] shifted;
    if (!entry_drives(entry)) return 1'b0;
    shifted = pins >> (side_base(entry[2:0]) + int'(entry[SEL_W-1:3]));
    return shifted[0];
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = LOAD;
      LOAD:    if (cfg_valid && (cnt == LAST_SLOT)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cfg_ready = (state == LOAD);
    cfg_done  = (state == COMMIT);
  end

  assign wr_en   = (state == LOAD) && cfg_valid;
  assign wr_ok   = entry_ok(cfg_data, cnt);
  assign cfg_err = err;

  // Slot counter and sticky error flag; both restart only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else if ((state == IDLE) && cfg_start) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (wr_en) begin
      cnt <= cnt + 1'b1;
      if (!wr_ok) err <= 1'b1;
    end
  end

  // Shadow fill and atomic commit into the active table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < P; s++) begin
        shadow[s] <= '0;
        active[s] <= '0;
      end
    end else begin
      if (wr_en) shadow[cnt] <= wr_ok ? cfg_data : '0;
      if (state == COMMIT) begin
        for (int s = 0; s < P; s++) active[s] <= shadow[s];
      end
    end
  end

  assign pins_in = {right_in, left_in, bottom_in, top_in};

  // ---- stage p0: combinational routing from the active table ----
  always_comb begin
    route_out = '0;
    route_oe  = '0;
    for (int s = 0; s < P; s++) begin
      route_out[s] = entry_bit(active[s], pins_in);
      route_oe[s]  = entry_drives(active[s]);
    end
  end

`ifdef SWM_OUT_REG_EN
  logic [P-1:0] out_p1;
  logic [P-1:0] oe_p1;

  // ---- stage p1: registered pin drivers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p1 <= '0;
      oe_p1  <= '0;
    end else begin
      out_p1 <= route_out;
      oe_p1  <= route_oe;
    end
  end

  assign pin_out = out_p1;
  assign pin_oe  = oe_p1;
`else
  assign pin_out = route_out;
  assign pin_oe  = route_oe;
`endif

  assign top_out    = pin_out[N_TB-1:0];
  assign bottom_out = pin_out[2*N_TB-1:N_TB];
  assign left_out   = pin_out[2*N_TB+N_LR-1:2*N_TB];
  assign right_out  = pin_out[P-1:2*N_TB+N_LR];
  assign top_oe     = pin_oe[N_TB-1:0];
  assign bottom_oe  = pin_oe[2*N_TB-1:N_TB];
  assign left_oe    = pin_oe[2*N_TB+N_LR-1:2*N_TB];
  assign right_oe   = pin_oe[P-1:2*N_TB+N_LR];

endmodule
